pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register: the successor to the fixed-field hold-only inter-stage registers. It carries one DATA_W payload between pipeline stages with a valid/ready handshake, stall (hold) and flush. An optional 2-entry skid buffer registers the upstream ready path. When the stage is empty or flushed it presents a configurable bubble value, for example INST_NOP for instruction fields.

Parameters:
DATA_W, 32, payload width in bits (≥1)
RST_VAL, 0, payload value presented on reset, flush and bubble (DATA_W bits)
SKID, 1, 1 = 2-entry skid buffer with registered ready; 0 = single entry with combinational ready

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-low reset (sampled on clk rising edge; 0 = reset)
in_valid_i  input  1  upstream payload valid
in_ready_o  output  1  stage can accept the payload this cycle
in_data_i  input  DATA_W  upstream payload
out_valid_o  output  1  stage presents a valid payload
out_ready_i  input  1  downstream accepts the payload this cycle
out_data_o  output  DATA_W  payload to downstream
hold_flag_i  input  1  stall from control: freeze all state
flush_i  input  1  discard all held entries
count_o  output  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Handshake qualifiers:
  - acc = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i & ~hold_flag_i.
  - in_ready_o = rdy_q & ~hold_flag_i, so no accept occurs during hold.
- Priority per edge: rst=0 > flush_i > hold_flag_i > normal operation.
- Reset, with rst=0 at the edge:
  - state EMPTY, out_valid_o=0, out_data_o=RST_VAL, count_o=0.
  - rdy_q=1, so in_ready_o=1 in the next cycle unless hold is asserted.
- Flush, with flush_i=1 at the edge, regardless of hold or in_valid_i:
  - state EMPTY, both entries invalidated, out_data_o=RST_VAL, rdy_q=1.
  - An input presented in the same cycle is dropped.
- Hold, with hold_flag_i=1 and no flush: no state change and outputs stable. out_valid_o stays asserted if already set; downstream must not count it as a transfer.
- SKID=1 states (main register M, skid register S):
  - EMPTY: acc → ONE (M←in). Otherwise stay EMPTY.
  - ONE:
    - acc & pop → ONE (M←in).
    - acc & ~pop → FULL (S←in).
    - ~acc & pop → EMPTY (M←RST_VAL).
    - Otherwise stay ONE.
  - FULL:
    - pop → ONE (M←S, S invalid).
    - acc is impossible because rdy_q=0.
  - rdy_q next = (next state ≠ FULL).
  - out_data_o = M.
  - out_valid_o = (state ≠ EMPTY).
  - count_o values: EMPTY=0, ONE=1, FULL=2.
- SKID=0:
  - rdy_q is unused.
  - in_ready_o = (~out_valid_o | out_ready_i) & ~hold_flag_i, a combinational path from out_ready_i.
  - acc → M←in, valid=1.
  - pop without acc → valid=0, M←RST_VAL.
  - count_o ∈ {0,1}.
- Ordering and integrity:
  - Strict FIFO order; no payload is duplicated or lost except by flush.
  - Back-to-back throughput is 1 transfer/cycle in both modes.
- Latency: an accepted payload appears on out_data_o on the cycle after acceptance when the stage was empty, or when in ONE with a simultaneous pop.
- Reset mid-operation: held entries are discarded as for flush; the reset values listed above apply.
- No outputs are X after the first reset edge.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid_i=1 → out_valid_o=0, out_data_o=RST_VAL, count_o=0. After release, in_ready_o=1.
- Streaming (SKID=1, out_ready_i=1): send 0x11, 0x22, 0x33 on consecutive cycles → out_data_o shows 0x11, 0x22, 0x33 on cycles N+1..N+3, with count_o=1 throughout.
- Backpressure:
  - Stimulus: with out_ready_i=0, send 0xA, 0xB.
  - Response: count_o=2, in_ready_o=0, 0xC is held off.
  - Then: raise out_ready_i → outputs 0xA, 0xB, 0xC in order, and in_ready_o returns 1 one cycle after the first pop.
- Hold: in FULL, assert hold_flag_i for 3 cycles with out_ready_i=1 → out_data_o stays 0xA, count_o stays 2, in_ready_o=0, no pop occurs.
- Flush priority:
  - Stimulus: in FULL, assert flush_i, hold_flag_i and in_valid_i (0xD) together.
  - Response: next cycle count_o=0, out_valid_o=0, out_data_o=RST_VAL (0x00000013 with RST_VAL=INST_NOP); 0xD never appears.
- SKID=0 mode:
  - Stimulus: hold out_ready_i=0 with out_valid_o=1.
  - Response: in_ready_o=0 in the same cycle; raising out_ready_i with in_valid_i=1 swaps the payload in one cycle, keeping count_o=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : valid/ready pipeline stage register with hold, flush and
//                  optional 2-entry skid buffer; presents RST_VAL when empty.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int                SKID    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              hold_flag_i,
  input  logic              flush_i,
  output logic [1:0]        count_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  logic w_acc;
  logic w_pop;

  assign w_acc = in_valid_i & in_ready_o;
  assign w_pop = out_valid_o & out_ready_i & ~hold_flag_i;

  generate
    if (SKID != 0) begin : g_skid
      state_t            r_state;
      logic [DATA_W-1:0] r_m;
      logic [DATA_W-1:0] r_s;
      logic              r_rdy;

      // Ready is registered: it drops only once the skid entry is occupied.
      always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
          r_state <= ST_EMPTY;
          r_m     <= RST_VAL;
          r_s     <= RST_VAL;
          r_rdy   <= 1'b1;
        end else if (!hold_flag_i) begin
          case (r_state)
            ST_EMPTY: begin
              if (w_acc) begin
                r_state <= ST_ONE;
                r_m     <= in_data_i;
              end
            end
            ST_ONE: begin
              if (w_acc && w_pop) begin
                r_m <= in_data_i;
              end else if (w_acc) begin
                r_state <= ST_FULL;
                r_s     <= in_data_i;
                r_rdy   <= 1'b0;
              end else if (w_pop) begin
                r_state <= ST_EMPTY;
                r_m     <= RST_VAL;
              end
            end
            ST_FULL: begin
              if (w_pop) begin
                r_state <= ST_ONE;
                r_m     <= r_s;
                r_s     <= RST_VAL;
                r_rdy   <= 1'b1;
              end
            end
            default: begin
              r_state <= ST_EMPTY;
              r_m     <= RST_VAL;
              r_s     <= RST_VAL;
              r_rdy   <= 1'b1;
            end
          endcase
        end
      end

      assign in_ready_o  = r_rdy & ~hold_flag_i;
      assign out_valid_o = (r_state != ST_EMPTY);
      assign out_data_o  = r_m;
      assign count_o     = (r_state == ST_FULL) ? 2'd2 :
                           (r_state == ST_ONE)  ? 2'd1 : 2'd0;
    end else begin : g_single
      logic              r_valid;
      logic [DATA_W-1:0] r_m;

      always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
          r_valid <= 1'b0;
          r_m     <= RST_VAL;
        end else if (!hold_flag_i) begin
          if (w_acc) begin
            r_valid <= 1'b1;
            r_m     <= in_data_i;
          end else if (w_pop) begin
            r_valid <= 1'b0;
            r_m     <= RST_VAL;
          end
        end
      end

      // Combinational ready: a downstream pop frees the slot in the same cycle.
      assign in_ready_o  = (~r_valid | out_ready_i) & ~hold_flag_i;
      assign out_valid_o = r_valid;
      assign out_data_o  = r_m;
      assign count_o     = {1'b0, r_valid};
    end
  endgenerate

endmodule

`default_nettype wire
